// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver: parity modes, FSM encoding,
// the received-flags record and the counter-width helper.
package uart_pkg;

    localparam int UART_CHK_NONE = 0;
    localparam int UART_CHK_ODD  = 1;
    localparam int UART_CHK_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic brk;
    } uart_flags_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int uart_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Received-frame delivery bus: data plus status flags under a valid/ready handshake,
// with the overrun pulse. The receiver drives the master side.
interface uart_rx_oversample_if
    import uart_pkg::*;
#(
    parameter int P_UART_DATA_WIDTH = 8
);
    logic [P_UART_DATA_WIDTH-1:0] o_uart_rx_data;
    logic                         o_uart_rx_valid;
    logic                         i_uart_rx_ready;
    logic                         o_parity_err;
    logic                         o_frame_err;
    logic                         o_break;
    logic                         o_overrun;

    modport master (
        output o_uart_rx_data, o_uart_rx_valid, o_parity_err, o_frame_err, o_break, o_overrun,
        input  i_uart_rx_ready
    );

    modport slave (
        input  o_uart_rx_data, o_uart_rx_valid, o_parity_err, o_frame_err, o_break, o_overrun,
        output i_uart_rx_ready
    );
endinterface

// File: rtl/uart_rx_oversample_sampler.sv
// Input synchroniser plus 3-tap mid-bit majority voter; o_vote is meaningful on the
// tick where the bit counter sits at the decision point (P_OSR/2+1).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int P_OSR         = 16,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                          i_u_clk,
    input  logic                          i_u_rst,
    input  logic                          i_os_tick,
    input  logic                          i_uart_rx,
    input  logic [uart_cnt_w(P_OSR)-1:0]  i_os_cnt,
    output logic                          o_line_sync,
    output logic                          o_vote
);
    localparam int OS_W = uart_cnt_w(P_OSR);
    localparam logic [OS_W-1:0] CNT_EARLY = OS_W'(P_OSR / 2 - 1);
    localparam logic [OS_W-1:0] CNT_MID   = OS_W'(P_OSR / 2);

    logic [P_SYNC_STAGES-1:0] sync_q;
    logic                     early_q;
    logic                     mid_q;

    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], i_uart_rx};
        end
    end

    assign o_line_sync = sync_q[P_SYNC_STAGES-1];

    // The third vote is the live sample on the decision tick itself.
    always_ff @(posedge i_u_clk) begin
        if (i_os_tick) begin
            if (i_os_cnt == CNT_EARLY) early_q <= o_line_sync;
            if (i_os_cnt == CNT_MID)   mid_q   <= o_line_sync;
        end
    end

    assign o_vote = (early_q & mid_q) | (early_q & o_line_sync) | (mid_q & o_line_sync);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampled UART receiver: glitch-rejecting start detect, voted data/parity/stop bits,
// break detection and a single-entry valid/ready holding register with overrun pulse.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0,
    parameter int P_OSR             = 16,
    parameter int P_SYNC_STAGES     = 2
) (
    input  logic                  i_u_clk,
    input  logic                  i_u_rst,
    input  logic                  i_os_tick,
    input  logic                  i_uart_rx,
    uart_rx_oversample_if.master  rx_if,
    output logic                  o_busy
);
    localparam int W     = P_UART_DATA_WIDTH;
    localparam int OS_W  = uart_cnt_w(P_OSR);
    localparam int BIT_W = uart_cnt_w(P_UART_DATA_WIDTH + 1);

    localparam logic [OS_W-1:0]  OS_ONE    = OS_W'(1);
    localparam logic [OS_W-1:0]  OS_DEC    = OS_W'(P_OSR / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(P_OSR - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(P_UART_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);

    function automatic logic parity_error(input logic [W-1:0] data, input logic par);
        logic odd_ones;
        odd_ones = ^{data, par};
        case (P_UART_CHECK)
            UART_CHK_ODD:  return ~odd_ones;
            UART_CHK_EVEN: return odd_ones;
            default:       return 1'b0;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             armed_q, armed_d;
    logic             ferr_q, ferr_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             par_q, par_d;

    logic             line_sync;
    logic             vote;
    logic             dec_pt;
    logic             bit_end;
    logic             complete;
    uart_flags_t      comp_flags;

    logic [W-1:0]     hold_data_q, hold_data_d;
    logic             hold_vld_q, hold_vld_d;
    uart_flags_t      hold_flags_q, hold_flags_d;
    logic             ovr_q, ovr_d;

    uart_rx_sampler #(
        .P_OSR         (P_OSR),
        .P_SYNC_STAGES (P_SYNC_STAGES)
    ) u_sampler (
        .i_u_clk     (i_u_clk),
        .i_u_rst     (i_u_rst),
        .i_os_tick   (i_os_tick),
        .i_uart_rx   (i_uart_rx),
        .i_os_cnt    (os_cnt_q),
        .o_line_sync (line_sync),
        .o_vote      (vote)
    );

    assign dec_pt  = (os_cnt_q == OS_DEC);
    assign bit_end = (os_cnt_q == OS_LAST);

    // Flags of the frame finishing on this tick; the last stop vote is still live here.
    always_comb begin
        comp_flags.parity_err = parity_error(shift_q, par_q);
        comp_flags.frame_err  = ferr_q | ~vote;
        comp_flags.brk        = ~|shift_q & ~par_q & ~vote;
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        armed_d   = armed_q;
        ferr_d    = ferr_q;
        shift_d   = shift_q;
        par_d     = par_q;
        complete  = 1'b0;
        if (i_os_tick) begin
            if (state_q != ST_IDLE) os_cnt_d = bit_end ? '0 : os_cnt_q + OS_ONE;
            case (state_q)
                ST_IDLE: begin
                    // The detecting tick is tick 0 of the start bit.
                    if (!armed_q) begin
                        armed_d = line_sync;
                    end else if (!line_sync) begin
                        state_d  = ST_START;
                        os_cnt_d = OS_ONE;
                        ferr_d   = 1'b0;
                        par_d    = 1'b0;
                    end
                end
                ST_START: begin
                    if (dec_pt && vote) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = '0;
                    end else if (bit_end) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (dec_pt) shift_d = {vote, shift_q[W-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d   = (P_UART_CHECK != UART_CHK_NONE) ? ST_PARITY : ST_STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (dec_pt) par_d = vote;
                    if (bit_end) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = '0;
                    end
                end
                ST_STOP: begin
                    // Leaving at the last stop decision point keeps half a bit of resync margin.
                    if (dec_pt) begin
                        if (!vote) ferr_d = 1'b1;
                        if (bit_cnt_q == STOP_LAST) begin
                            complete  = 1'b1;
                            state_d   = ST_IDLE;
                            os_cnt_d  = '0;
                            bit_cnt_d = '0;
                            if (comp_flags.brk) armed_d = 1'b0;
                        end
                    end else if (bit_end) begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        hold_vld_d   = hold_vld_q;
        hold_data_d  = hold_data_q;
        hold_flags_d = hold_flags_q;
        ovr_d        = 1'b0;
        if (complete) begin
            if (!hold_vld_q || rx_if.i_uart_rx_ready) begin
                hold_vld_d   = 1'b1;
                hold_data_d  = shift_q;
                hold_flags_d = comp_flags;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (hold_vld_q && rx_if.i_uart_rx_ready) begin
            hold_vld_d   = 1'b0;
            hold_flags_d = '0;
        end
    end

    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            state_q      <= ST_IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            armed_q      <= 1'b1;
            ferr_q       <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            hold_flags_q <= '0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            armed_q      <= armed_d;
            ferr_q       <= ferr_d;
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            hold_flags_q <= hold_flags_d;
            ovr_q        <= ovr_d;
        end
    end

    always_ff @(posedge i_u_clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign rx_if.o_uart_rx_data  = hold_data_q;
    assign rx_if.o_uart_rx_valid = hold_vld_q;
    assign rx_if.o_parity_err    = hold_flags_q.parity_err;
    assign rx_if.o_frame_err     = hold_flags_q.frame_err;
    assign rx_if.o_break         = hold_flags_q.brk;
    assign rx_if.o_overrun       = ovr_q;
    assign o_busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: an 8N1 and an 8E1 receiver share one tick-level line
// waveform; a bit-time model predicts frames and a cycle scoreboard checks every cycle.
module tb_uart_rx_oversample;
    localparam int OSR  = 16;
    localparam int M    = OSR / 2;
    localparam int MAXT = 4096;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } fr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic line = 1'b1;
    logic rdy = 1'b0;
    logic busy0, busy1;

    int n_chk = 0;
    int n_err = 0;

    uart_rx_oversample_if #(.P_UART_DATA_WIDTH(8)) if0 ();
    uart_rx_oversample_if #(.P_UART_DATA_WIDTH(8)) if1 ();
    assign if0.i_uart_rx_ready = rdy;
    assign if1.i_uart_rx_ready = rdy;

    uart_rx_oversample #(
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0),
        .P_OSR(OSR), .P_SYNC_STAGES(2)
    ) dut0 (
        .i_u_clk(clk), .i_u_rst(rst), .i_os_tick(tick), .i_uart_rx(line),
        .rx_if(if0), .o_busy(busy0)
    );

    uart_rx_oversample #(
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2),
        .P_OSR(OSR), .P_SYNC_STAGES(2)
    ) dut1 (
        .i_u_clk(clk), .i_u_rst(rst), .i_os_tick(tick), .i_uart_rx(line),
        .rx_if(if1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    logic av[2], ao[2], ab[2];
    fr_t  af[2];
    assign av[0] = if0.o_uart_rx_valid;
    assign av[1] = if1.o_uart_rx_valid;
    assign ao[0] = if0.o_overrun;
    assign ao[1] = if1.o_overrun;
    assign ab[0] = busy0;
    assign ab[1] = busy1;
    assign af[0] = {if0.o_uart_rx_data, if0.o_parity_err, if0.o_frame_err, if0.o_break};
    assign af[1] = {if1.o_uart_rx_data, if1.o_parity_err, if1.o_frame_err, if1.o_break};

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h, want %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Stimulus: one line sample and one ready code per tick (0 low, 1 high, 2 tick cycle only).
    bit line_a[$];
    int rdy_a[$];
    int cur_rdy = 1;

    task automatic push(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            line_a.push_back(v);
            rdy_a.push_back(cur_rdy);
        end
    endtask

    task automatic send(input logic [7:0] d, input int par, input bit stop_v, output int s);
        s = line_a.size();
        push(1'b0, OSR);
        for (int i = 0; i < 8; i++) push(d[i], OSR);
        if (par >= 0) push(par[0], OSR);
        push(stop_v, OSR);
        push(1'b1, 2 * OSR);
    endtask

    // Bit-time model: tick indices of frame events, from bit arithmetic on the line samples.
    bit  comp_m[2][MAXT];
    bit  st_m[2][MAXT];
    bit  en_m[2][MAXT];
    fr_t fr_m[2][MAXT];

    function automatic bit ln(input int t);
        return (t < line_a.size()) ? line_a[t] : 1'b1;
    endfunction

    function automatic bit vote_at(input int s, input int k);
        bit a, b, c;
        a = ln(s + OSR * k + M - 1);
        b = ln(s + OSR * k + M);
        c = ln(s + OSR * k + M + 1);
        return (a & b) | (a & c) | (b & c);
    endfunction

    task automatic build_model(input int inst, input bit has_par);
        int t;
        bit armed;
        t = 0;
        armed = 1'b1;
        while (t < line_a.size()) begin
            if (!armed) begin
                if (ln(t)) armed = 1'b1;
                t++;
            end else if (ln(t)) begin
                t++;
            end else begin : frame
                int s, k, c;
                logic [7:0] d;
                bit p, sb;
                fr_t f;
                s = t;
                st_m[inst][s] = 1'b1;
                if (vote_at(s, 0)) begin
                    en_m[inst][s + M + 1] = 1'b1;
                    t = s + M + 2;
                end else begin
                    for (int i = 0; i < 8; i++) d[i] = vote_at(s, 1 + i);
                    k = 9;
                    p = 1'b0;
                    if (has_par) begin
                        p = vote_at(s, k);
                        k++;
                    end
                    sb = vote_at(s, k);
                    c = s + OSR * k + M + 1;
                    f.data = d;
                    f.fe   = ~sb;
                    f.brk  = (d == 8'h00) && !p && !sb;
                    f.pe   = has_par && ((^d) ^ p);
                    comp_m[inst][c] = 1'b1;
                    fr_m[inst][c]   = f;
                    en_m[inst][c]   = 1'b1;
                    if (f.brk) armed = 1'b0;
                    t = c + 1;
                end
            end
        end
    endtask

    function automatic int count_comps(input int inst, input int lo, input int hi);
        int n;
        n = 0;
        for (int t = lo; t <= hi; t++) if (comp_m[inst][t]) n++;
        return n;
    endfunction

    // Cycle scoreboard of the holding register, stepped by observed tick/ready inputs.
    bit  vm[2];
    fr_t hm[2];
    bit  om[2];
    bit  bm[2];
    int  tk;
    bit  run_chk = 1'b0;
    int  ovr_cnt[2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                vm[i] = 1'b0;
                hm[i] = '0;
                om[i] = 1'b0;
                bm[i] = 1'b0;
            end
            tk = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                om[i] = 1'b0;
                if (tick && comp_m[i][tk]) begin
                    if (!vm[i] || rdy) begin
                        vm[i] = 1'b1;
                        hm[i] = fr_m[i][tk];
                    end else begin
                        om[i] = 1'b1;
                    end
                end else if (rdy) begin
                    vm[i] = 1'b0;
                end
                if (tick && st_m[i][tk]) bm[i] = 1'b1;
                if (tick && en_m[i][tk]) bm[i] = 1'b0;
            end
            if (tick) tk++;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < 2; i++) begin
                check("valid", i, av[i], vm[i]);
                check("overrun", i, ao[i], om[i]);
                check("busy", i, ab[i], bm[i]);
                if (ao[i]) ovr_cnt[i]++;
                if (vm[i]) begin
                    check("data", i, af[i].data, hm[i].data);
                    check("parity_err", i, af[i].pe, hm[i].pe);
                    check("frame_err", i, af[i].fe, hm[i].fe);
                    check("break", i, af[i].brk, hm[i].brk);
                end else begin
                    check("flags_idle", i, {af[i].pe, af[i].fe, af[i].brk}, 3'b000);
                end
            end
        end
    end

    initial begin
        int sA, sg, s3c, sp1, sp2, sm, ss, sb, s11, s22, s33;

        push(1'b1, 20);
        send(8'hA5, -1, 1'b1, sA);
        sg = line_a.size();
        push(1'b0, 4);
        push(1'b1, 2 * OSR);
        send(8'h3C, -1, 1'b1, s3c);
        send(8'h07, 0, 1'b1, sp1);
        send(8'h07, 1, 1'b1, sp2);
        send(8'hFF, -1, 1'b1, sm);
        line_a[sm + OSR * 4 + M] = 1'b0;
        send(8'h55, -1, 1'b0, ss);
        push(1'b1, 2 * OSR);
        sb = line_a.size();
        push(1'b0, 30 * OSR);
        push(1'b1, 4 * OSR);
        cur_rdy = 0;
        send(8'h11, -1, 1'b1, s11);
        send(8'h22, -1, 1'b1, s22);
        send(8'h33, -1, 1'b1, s33);
        rdy_a[s33 + 153] = 2;
        cur_rdy = 1;
        push(1'b1, 4 * OSR);

        build_model(0, 1'b0);
        build_model(1, 1'b1);

        // Hand-derived anchors for the model.
        check("m_a5_tick", 0, comp_m[0][sA + 153], 1);
        check("m_a5_data", 0, fr_m[0][sA + 153], {8'hA5, 3'b000});
        check("m_glitch_end", 0, en_m[0][sg + 9], 1);
        check("m_glitch_none", 0, count_comps(0, sg, s3c - 1), 0);
        check("m_3c_data", 0, fr_m[0][s3c + 153].data, 8'h3C);
        check("m_par_bad", 1, fr_m[1][sp1 + 169], {8'h07, 3'b100});
        check("m_par_good", 1, fr_m[1][sp2 + 169], {8'h07, 3'b000});
        check("m_vote_ff", 0, fr_m[0][sm + 153], {8'hFF, 3'b000});
        check("m_stop0", 0, fr_m[0][ss + 153], {8'h55, 3'b010});
        check("m_break", 0, fr_m[0][sb + 153], {8'h00, 3'b011});
        check("m_break_once", 0, count_comps(0, sb + 154, sb + 30 * OSR), 0);
        check("m_break_once", 1, count_comps(1, sb + 170, sb + 30 * OSR), 0);
        check("m_33_tick", 0, comp_m[0][s33 + 153], 1);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", i, av[i], 0);
            check("rst_data", i, af[i].data, 0);
            check("rst_flags", i, {af[i].pe, af[i].fe, af[i].brk}, 0);
            check("rst_overrun", i, ao[i], 0);
            check("rst_busy", i, ab[i], 0);
        end
        rst = 1'b0;
        run_chk = 1'b1;

        for (int t = 0; t < line_a.size(); t++) begin
            @(negedge clk);
            tick = 1'b0;
            line = line_a[t];
            rdy  = (rdy_a[t] == 1);
            repeat (2) @(negedge clk);
            @(negedge clk);
            tick = 1'b1;
            rdy  = (rdy_a[t] != 0);
        end
        @(negedge clk);
        tick = 1'b0;
        rdy  = 1'b1;
        repeat (20) @(negedge clk);
        run_chk = 1'b0;

        check("overrun_pulses", 0, ovr_cnt[0], 1);
        check("overrun_pulses", 1, ovr_cnt[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
